// File: rtl/go_pkg.sv
// Shared types and constants for the board-to-board move link.
// move_chk is also used by the matching receiver.
package go_pkg;

   typedef logic [7:0] move_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

   localparam move_t SYNC_BYTE = 8'hA5;
   localparam move_t PASS_MOVE = 8'hFF;

   function automatic move_t move_chk(input move_t m);
      return ~(SYNC_BYTE ^ m);
   endfunction

endpackage

// File: rtl/baud_gen.sv
// Bit-period timer: tick pulses on the last cycle of every CLKS_PER_BIT enabled cycles.
// clear restarts the period so a new frame is phase-aligned to its accept edge.
module baud_gen #(
   parameter int CLKS_PER_BIT = 564
) (
   input  logic clk_in,
   input  logic rst_in_n,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] r_cnt;

   // Cycle counter within the current bit period
   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (enable) begin
         if (r_cnt == LAST) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign tick = enable && !clear && (r_cnt == LAST);

endmodule

// File: rtl/move_uart_tx.sv
// Sends an accepted move as three back-to-back 8N1 bytes: SYNC, MOVE, CHECKSUM.
// All status outputs are registered; tx_ready while a frame is in flight only flags overrun.
module move_uart_tx
   import go_pkg::*;
#(
   parameter int CLK_HZ       = 65_000_000,
   parameter int BAUD         = 115_200,
   parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
   input  logic       clk_in,
   input  logic       rst_in_n,
   input  logic       tx_ready,
   input  logic [7:0] move,
   output logic       tx_out,
   output logic       busy,
   output logic       tx_done,
   output logic       overrun
);

   tx_state_t  r_state;
   tx_state_t  w_state_nxt;
   logic       w_tick;
   logic       w_accept;
   logic [1:0] r_byte_idx;
   logic [2:0] r_bit_idx;
   move_t      r_shift;
   move_t      r_move;
   move_t      r_chk;
   logic       w_tx_nxt;
   logic       w_busy_nxt;
   logic       w_done_nxt;
   logic       w_ovr_nxt;

   assign w_accept = (r_state == ST_IDLE) && tx_ready;

   baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_gen (
      .clk_in  (clk_in),
      .rst_in_n(rst_in_n),
      .clear   (w_accept),
      .enable  (busy),
      .tick    (w_tick)
   );

   // Frame state register
   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; every transition after accept waits for the baud tick
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  w_state_nxt = tx_ready ? ST_START : ST_IDLE;
         ST_START: w_state_nxt = w_tick ? ST_DATA : ST_START;
         ST_DATA: begin
            if (w_tick && (r_bit_idx == 3'd7)) begin
               w_state_nxt = ST_STOP;
            end else begin
               w_state_nxt = ST_DATA;
            end
         end
         ST_STOP: begin
            if (w_tick) begin
               w_state_nxt = (r_byte_idx == 2'd2) ? ST_IDLE : ST_START;
            end else begin
               w_state_nxt = ST_STOP;
            end
         end
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Byte/bit counters and shift register; move and checksum are captured only at accept
   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         r_byte_idx <= 2'd0;
         r_bit_idx  <= 3'd0;
         r_shift    <= 8'h00;
         r_move     <= 8'h00;
         r_chk      <= 8'h00;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (tx_ready) begin
                  r_move     <= move;
                  r_chk      <= move_chk(move);
                  r_shift    <= SYNC_BYTE;
                  r_byte_idx <= 2'd0;
                  r_bit_idx  <= 3'd0;
               end
            end
            ST_DATA: begin
               if (w_tick) begin
                  r_shift   <= {1'b0, r_shift[7:1]};
                  r_bit_idx <= r_bit_idx + 3'd1;
               end
            end
            ST_STOP: begin
               if (w_tick && (r_byte_idx != 2'd2)) begin
                  r_byte_idx <= r_byte_idx + 2'd1;
                  r_shift    <= (r_byte_idx == 2'd0) ? r_move : r_chk;
               end
            end
            default: begin
               r_shift <= r_shift;
            end
         endcase
      end
   end

   // Next values of the registered outputs
   always_comb begin
      w_tx_nxt = tx_out;
      case (r_state)
         ST_IDLE:  w_tx_nxt = tx_ready ? 1'b0 : 1'b1;
         ST_START: w_tx_nxt = w_tick ? r_shift[0] : tx_out;
         ST_DATA: begin
            if (w_tick) begin
               w_tx_nxt = (r_bit_idx == 3'd7) ? 1'b1 : r_shift[1];
            end else begin
               w_tx_nxt = tx_out;
            end
         end
         ST_STOP: begin
            if (w_tick) begin
               w_tx_nxt = (r_byte_idx == 2'd2) ? 1'b1 : 1'b0;
            end else begin
               w_tx_nxt = tx_out;
            end
         end
         default:  w_tx_nxt = 1'b1;
      endcase
      w_busy_nxt = (w_state_nxt != ST_IDLE);
      w_done_nxt = (r_state == ST_STOP) && w_tick && (r_byte_idx == 2'd2);
      w_ovr_nxt  = tx_ready && (r_state != ST_IDLE);
   end

   // Output registers; reset drives the line idle-high immediately
   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         tx_out  <= 1'b1;
         busy    <= 1'b0;
         tx_done <= 1'b0;
         overrun <= 1'b0;
      end else begin
         tx_out  <= w_tx_nxt;
         busy    <= w_busy_nxt;
         tx_done <= w_done_nxt;
         overrun <= w_ovr_nxt;
      end
   end

endmodule
